// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer for the 90 MHz rPLL, running entirely in the 27 MHz
// reference domain. Pulses the PLL RESET, waits for LOCK and retries after a
// timeout, then qualifies LOCK as stable. Only after that does it release the
// downstream datapath reset. It also owns the dynamic duty-adjust value, which
// is updated through a req/ack handshake.
module pll_lock_sequencer #(
    parameter int unsigned RST_CYCLES    = 27,
    parameter int unsigned LOCK_TIMEOUT  = 27000,
    parameter int unsigned STABLE_CYCLES = 2700,
    parameter int unsigned CNT_W         = 16,
    parameter logic [3:0]  DUTYDA_INIT   = 4'b1000
) (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [3:0] pll_dutyda,
    output logic       rst_out_n,
    output logic       locked,
    input  logic       dutyda_req,
    input  logic [3:0] dutyda_in,
    output logic       dutyda_ack,
    output logic [7:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    typedef enum logic [1:0] {
        ST_RST_PLL,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN
    } state_e;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMER_MAX    = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             lock_meta_q, lock_s_q;
    logic             pll_reset_q, pll_reset_d;
    logic             rst_out_n_q, rst_out_n_d;
    logic             locked_q, locked_d;
    logic [3:0]       dutyda_q, dutyda_d;
    logic             ack_q, ack_d;
    logic [7:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;

    // Two-flop synchronizer bringing the asynchronous PLL LOCK into clkin.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    // Next state, timer, counters and duty handshake; outputs derive from the next state so they are registered.
    always_comb begin
        state_d  = state_q;
        timer_d  = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
        retry_d  = retry_q;
        loss_d   = loss_q;
        dutyda_d = dutyda_q;
        ack_d    = 1'b0;

        case (state_q)
            ST_RST_PLL: begin
                if (timer_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = ST_STABLE;
                    timer_d = '0;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d = ST_RST_PLL;
                    timer_d = '0;
                    if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
                end
            end
            ST_STABLE: begin
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    timer_d = '0;
                end
            end
            ST_RUN: begin
                if (!lock_s_q) begin
                    state_d = ST_RST_PLL;
                    timer_d = '0;
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                end else if (dutyda_req && !ack_q) begin
                    dutyda_d = dutyda_in;
                    ack_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_RST_PLL;
                timer_d = '0;
            end
        endcase

        pll_reset_d = (state_d == ST_RST_PLL);
        rst_out_n_d = (state_d == ST_RUN);
        locked_d    = (state_d == ST_RUN);
    end

    // State, timer and all registered outputs.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RST_PLL;
            timer_q     <= '0;
            pll_reset_q <= 1'b1;
            rst_out_n_q <= 1'b0;
            locked_q    <= 1'b0;
            dutyda_q    <= DUTYDA_INIT;
            ack_q       <= 1'b0;
            retry_q     <= 8'd0;
            loss_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            pll_reset_q <= pll_reset_d;
            rst_out_n_q <= rst_out_n_d;
            locked_q    <= locked_d;
            dutyda_q    <= dutyda_d;
            ack_q       <= ack_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
        end
    end

    assign pll_reset  = pll_reset_q;
    assign pll_dutyda = dutyda_q;
    assign rst_out_n  = rst_out_n_q;
    assign locked     = locked_q;
    assign dutyda_ack = ack_q;
    assign retry_cnt  = retry_q;
    assign loss_cnt   = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short timing parameters
// (RST=4, TIMEOUT=50, STABLE=10). Inputs change and outputs are sampled on the
// falling edge. Comments of the form [k+n] count rising edges from a reference.
module tb_pll_lock_sequencer;

    logic       clkin;
    logic       rst_n;
    logic       pll_lock;
    logic       pll_reset;
    logic [3:0] pll_dutyda;
    logic       rst_out_n;
    logic       locked;
    logic       dutyda_req;
    logic [3:0] dutyda_in;
    logic       dutyda_ack;
    logic [7:0] retry_cnt;
    logic [7:0] loss_cnt;

    int checksPassed = 0;
    int checksFailed = 0;
    int checksTotal  = 0;

    pll_lock_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (50),
        .STABLE_CYCLES(10),
        .CNT_W        (16),
        .DUTYDA_INIT  (4'b1000)
    ) dut (
        .clkin     (clkin),
        .rst_n     (rst_n),
        .pll_lock  (pll_lock),
        .pll_reset (pll_reset),
        .pll_dutyda(pll_dutyda),
        .rst_out_n (rst_out_n),
        .locked    (locked),
        .dutyda_req(dutyda_req),
        .dutyda_in (dutyda_in),
        .dutyda_ack(dutyda_ack),
        .retry_cnt (retry_cnt),
        .loss_cnt  (loss_cnt)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    task automatic applyStimulus(input logic lock, input logic req, input logic [3:0] din);
        pll_lock   = lock;
        dutyda_req = req;
        dutyda_in  = din;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clkin);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checksTotal++;
        assert (observed === expected) checksPassed++;
        else begin
            checksFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        int waited;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h0);
        tick(2);

        // Reset state.
        checkOutput("rst pll_reset", 32'(pll_reset), 32'd1);
        checkOutput("rst rst_out_n", 32'(rst_out_n), 32'd0);
        checkOutput("rst locked", 32'(locked), 32'd0);
        checkOutput("rst dutyda", 32'(pll_dutyda), 32'h8);
        checkOutput("rst ack", 32'(dutyda_ack), 32'd0);
        checkOutput("rst retry", 32'(retry_cnt), 32'd0);
        checkOutput("rst loss", 32'(loss_cnt), 32'd0);

        // Nominal lock: PLL reset is held for 4 cycles after release.
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            checkOutput($sformatf("pll_reset pulse e%0d", i), 32'(pll_reset), (i < 4) ? 32'd1 : 32'd0);
        end
        tick(5);
        applyStimulus(1'b1, 1'b0, 4'h0);
        tick(12);
        checkOutput("nominal rst_out_n early", 32'(rst_out_n), 32'd0);
        checkOutput("nominal locked early", 32'(locked), 32'd0);
        tick(1);
        checkOutput("nominal rst_out_n", 32'(rst_out_n), 32'd1);
        checkOutput("nominal locked", 32'(locked), 32'd1);
        checkOutput("nominal retry", 32'(retry_cnt), 32'd0);
        checkOutput("nominal pll_reset", 32'(pll_reset), 32'd0);

        // Duty update in RUN, then a held request that is accepted again after the ack gap.
        applyStimulus(1'b1, 1'b1, 4'b0110);
        tick(1);
        checkOutput("duty ack", 32'(dutyda_ack), 32'd1);
        checkOutput("duty value", 32'(pll_dutyda), 32'h6);
        applyStimulus(1'b1, 1'b0, 4'b0110);
        tick(1);
        checkOutput("duty ack drop", 32'(dutyda_ack), 32'd0);
        applyStimulus(1'b1, 1'b1, 4'b0011);
        tick(1);
        checkOutput("duty2 ack", 32'(dutyda_ack), 32'd1);
        checkOutput("duty2 value", 32'(pll_dutyda), 32'h3);
        tick(1);
        checkOutput("duty held gap", 32'(dutyda_ack), 32'd0);
        tick(1);
        checkOutput("duty held reaccept", 32'(dutyda_ack), 32'd1);
        applyStimulus(1'b1, 1'b0, 4'b0011);
        tick(1);
        checkOutput("duty held drop", 32'(dutyda_ack), 32'd0);

        // Loss in RUN: one-cycle drop of pll_lock, with a duty request colliding with the loss edge.
        applyStimulus(1'b0, 1'b0, 4'b0011);
        tick(1);                                    // [k+1]
        checkOutput("loss k+1 rst_out_n", 32'(rst_out_n), 32'd1);
        applyStimulus(1'b1, 1'b0, 4'b0011);
        tick(1);                                    // [k+2]
        checkOutput("loss k+2 rst_out_n", 32'(rst_out_n), 32'd1);
        applyStimulus(1'b1, 1'b1, 4'b0110);
        tick(1);                                    // [k+3]
        checkOutput("loss rst_out_n", 32'(rst_out_n), 32'd0);
        checkOutput("loss locked", 32'(locked), 32'd0);
        checkOutput("loss cnt", 32'(loss_cnt), 32'd1);
        checkOutput("loss pll_reset", 32'(pll_reset), 32'd1);
        checkOutput("loss no ack", 32'(dutyda_ack), 32'd0);
        checkOutput("loss dutyda kept", 32'(pll_dutyda), 32'h3);
        tick(3);                                    // [k+6]
        checkOutput("loss pll_reset k+6", 32'(pll_reset), 32'd1);
        tick(1);                                    // [k+7]
        checkOutput("loss pll_reset k+7", 32'(pll_reset), 32'd0);

        // Glitch in STABLE: 3-cycle drop of pll_lock restarts qualification.
        tick(5);                                    // [k+12]
        applyStimulus(1'b0, 1'b1, 4'b0110);
        tick(3);                                    // [k+15]
        applyStimulus(1'b1, 1'b1, 4'b0110);
        tick(3);                                    // [k+18]
        checkOutput("glitch delays release", 32'(rst_out_n), 32'd0);
        checkOutput("glitch loss", 32'(loss_cnt), 32'd1);
        checkOutput("glitch retry", 32'(retry_cnt), 32'd0);
        tick(9);                                    // [k+27]
        checkOutput("glitch rst_out_n early", 32'(rst_out_n), 32'd0);
        checkOutput("pending no ack", 32'(dutyda_ack), 32'd0);
        tick(1);                                    // [k+28]
        checkOutput("glitch rst_out_n", 32'(rst_out_n), 32'd1);
        checkOutput("glitch locked", 32'(locked), 32'd1);
        checkOutput("pending ack not yet", 32'(dutyda_ack), 32'd0);
        checkOutput("dutyda across relock", 32'(pll_dutyda), 32'h3);
        tick(1);                                    // [k+29]
        checkOutput("pending ack", 32'(dutyda_ack), 32'd1);
        checkOutput("pending value", 32'(pll_dutyda), 32'h6);

        // No lock: drop pll_lock for good and watch the retry cadence.
        applyStimulus(1'b0, 1'b0, 4'b0110);
        tick(1);                                    // [j+1]
        checkOutput("pending ack drop", 32'(dutyda_ack), 32'd0);
        tick(2);                                    // [j+3]
        checkOutput("second loss cnt", 32'(loss_cnt), 32'd2);
        checkOutput("second loss rst_out_n", 32'(rst_out_n), 32'd0);
        tick(53);                                   // [j+56]
        checkOutput("timeout pll_reset before", 32'(pll_reset), 32'd0);
        checkOutput("timeout retry before", 32'(retry_cnt), 32'd0);
        tick(1);                                    // [j+57]
        checkOutput("timeout pll_reset", 32'(pll_reset), 32'd1);
        checkOutput("timeout retry 1", 32'(retry_cnt), 32'd1);
        tick(53);                                   // [j+110]
        checkOutput("timeout2 pll_reset before", 32'(pll_reset), 32'd0);
        tick(1);                                    // [j+111]
        checkOutput("timeout2 pll_reset", 32'(pll_reset), 32'd1);
        checkOutput("timeout retry 2", 32'(retry_cnt), 32'd2);
        tick(54 * 253);
        checkOutput("retry reaches 255", 32'(retry_cnt), 32'd255);
        tick(54);
        checkOutput("retry saturates", 32'(retry_cnt), 32'd255);
        tick(54 * 45);
        checkOutput("retry after 301", 32'(retry_cnt), 32'd255);
        checkOutput("no lock rst_out_n", 32'(rst_out_n), 32'd0);
        checkOutput("no lock locked", 32'(locked), 32'd0);

        // Re-lock, then assert rst_n asynchronously in RUN.
        applyStimulus(1'b1, 1'b0, 4'b0000);
        waited = 0;
        while (!locked && waited < 500) begin
            tick(1);
            waited++;
        end
        checkOutput("relock", 32'(locked), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async pll_reset", 32'(pll_reset), 32'd1);
        checkOutput("async rst_out_n", 32'(rst_out_n), 32'd0);
        checkOutput("async locked", 32'(locked), 32'd0);
        checkOutput("async retry", 32'(retry_cnt), 32'd0);
        checkOutput("async loss", 32'(loss_cnt), 32'd0);
        checkOutput("async dutyda", 32'(pll_dutyda), 32'h8);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sequences the 90 MHz rPLL from the 27 MHz board clock.
- Pulses the PLL RESET, waits for LOCK with a timeout-and-retry, and qualifies LOCK as stable.
- Releases a synchronous active-low reset to the 90 MHz datapath (spectrogram pipeline) only while lock holds.
- Owns the PLL dynamic duty-adjust input (DUTYDA) and accepts updates through a req/ack handshake, applied only while running.

Parameters:
- RST_CYCLES, 27: cycles the PLL RESET is held high per attempt (1 us at 27 MHz).
- LOCK_TIMEOUT, 27000: cycles to wait for synchronized lock before retrying (1 ms).
- STABLE_CYCLES, 2700: consecutive cycles lock must stay high before release (100 us).
- CNT_W, 16: width of the timer; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).
- DUTYDA_INIT, 4'b1000: DUTYDA value applied at reset (50 % duty).

Ports:
- clkin  input  1  27 MHz reference clock; all logic in this domain.
- rst_n  input  1  asynchronous active-low reset.
- pll_lock  input  1  rPLL LOCK; asynchronous to clkin.
- pll_reset  output  1  drives rPLL RESET, active high.
- pll_dutyda  output  4  drives rPLL DUTYDA.
- rst_out_n  output  1  active-low reset for the downstream datapath; synchronous deassert.
- locked  output  1  high while in RUN.
- dutyda_req  input  1  request to load dutyda_in.
- dutyda_in  input  4  new duty value.
- dutyda_ack  output  1  one-cycle pulse when dutyda_in is applied.
- retry_cnt  output  8  saturating count of lock timeouts.
- loss_cnt  output  8  saturating count of lock losses while in RUN.

Behaviour:
- Reset values (rst_n low, asynchronous):
  - State RST_PLL, timer 0, pll_reset=1, rst_out_n=0, locked=0.
  - pll_dutyda=DUTYDA_INIT, dutyda_ack=0, retry_cnt=0, loss_cnt=0, synchronizer flops 0.
- pll_lock passes through a 2-flop synchronizer; lock_s below is the synchronized value (2-cycle latency).
- All outputs are registered.
- State RST_PLL:
  - pll_reset=1; timer counts up.
  - When timer==RST_CYCLES-1: go to WAIT_LOCK, clear timer.
- State WAIT_LOCK:
  - pll_reset=0.
  - If lock_s=1: go to STABLE, clear timer.
  - Else if timer==LOCK_TIMEOUT-1: go to RST_PLL and increment retry_cnt, saturating at 255.
  - If both occur in the same cycle, lock_s=1 wins.
- State STABLE:
  - If lock_s=0: go to WAIT_LOCK, clear timer. No retry or loss count.
  - Else if timer==STABLE_CYCLES-1: go to RUN.
- State RUN:
  - rst_out_n=1 and locked=1, both registered, from the first cycle in RUN.
  - If lock_s=0: go to RST_PLL, increment loss_cnt (saturating), clear timer.
  - rst_out_n=0 and locked=0 take effect in the same cycle the state leaves RUN.
- rst_out_n is 0 in every state other than RUN.
- Release latency with pll_lock stable high from the end of the reset pulse: RST_CYCLES + 2 (sync) + STABLE_CYCLES + 1 cycles from rst_n deassert.
- Duty handshake:
  - dutyda_req is level-sensitive; the requester holds req and data stable until it sees ack.
  - Accepted only in RUN and when dutyda_ack is 0: pll_dutyda<=dutyda_in and dutyda_ack=1 for exactly one cycle.
  - The requester drops req in the cycle after ack. A req still high the cycle after ack is treated as a new request.
  - A req raised outside RUN stays pending (no ack) until RUN is reached.
  - pll_dutyda persists across PLL re-lock; it returns to DUTYDA_INIT only on rst_n.
- Lock loss in the same cycle as a duty accept: the state transition takes priority and no ack is issued.
- Timer never wraps; it is cleared on every state change.

Test Plan:
- Nominal lock (params RST=4, TIMEOUT=50, STABLE=10); release rst_n, pll_lock rises 5 cycles after pll_reset falls and stays high -> pll_reset high for exactly 4 cycles, rst_out_n and locked rise 1+2+10 cycles after pll_lock rises, retry_cnt=0.
- No lock: pll_lock held 0 -> pll_reset re-pulses every 54 cycles, retry_cnt increments by 1 per timeout; after 300 timeouts retry_cnt=255, rst_out_n stays 0.
- Glitch in STABLE: pll_lock drops for 3 cycles at cycle 6 of STABLE -> back to WAIT_LOCK, timer restarts, no retry or loss count, release 10 cycles after lock_s returns.
- Loss in RUN: drop pll_lock for 1 cycle -> rst_out_n=0 and locked=0 3 cycles later (sync + 1), loss_cnt=1, pll_reset pulses 4 cycles, full re-lock sequence, pll_dutyda unchanged.
- Duty update: in RUN, req=1 with dutyda_in=4'b0110 -> pll_dutyda=0110 and a single ack pulse next cycle. The same req raised before lock -> no ack until 1 cycle after rst_out_n rises.
- Async reset mid-RUN: assert rst_n low -> immediately pll_reset=1, rst_out_n=0, counters 0, pll_dutyda=1000.
